// File: rtl/ws2812_pixel_serializer.sv
// Whole-pixel WS2812B serializer: shifts pixel words out MSB-first as timed
// high/low pulses, back-to-back, and generates the end-of-frame latch period.
module ws2812_pixel_serializer #(
  parameter int PIXEL_BITS = 24,
  parameter int BIT_CYC    = 120,
  parameter int T0H_CYC    = 35,
  parameter int T1H_CYC    = 70,
  parameter int RESET_CYC  = 6000,
  parameter int CNT_W      = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] pixelData,
  input  logic                  pixelValid,
  output logic                  pixelReady,
  input  logic                  latchReq,
  output logic                  dataOut,
  output logic                  busy,
  output logic                  pixelDone,
  output logic                  latchDone,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a pixel is taken on any rising clk edge where pixelValid and
  // pixelReady are both high; pixelData must be stable while pixelValid is high.

  localparam int IDX_W = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXEL_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PIXEL_BITS-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d;

  logic bit_end, pixel_end, latch_end;

  assign bit_end   = (state_q == S_SEND) && (cyc_q == BIT_LAST);
  assign pixel_end = bit_end && (idx_q == IDX_LAST);
  assign latch_end = (state_q == S_LATCH) && (cyc_q == RST_LAST);

  // dataOut comes from registers only so the pin never glitches on input activity.
  assign dataOut     = (state_q == S_SEND) &&
                       (cyc_q < (shift_q[PIXEL_BITS-1] ? T1H : T0H));
  assign pixelReady  = !reset && ((state_q == S_IDLE) || pixel_end);
  assign busy        = !reset && (state_q != S_IDLE);
  assign pixelDone   = !reset && pixel_end;
  assign latchDone   = !reset && latch_end;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (pixelValid) begin
          shift_d = pixelData;
          idx_d   = '0;
          cyc_d   = '0;
          state_d = S_SEND;
        end else if (latchReq) begin
          cyc_d   = '0;
          state_d = S_LATCH;
        end
      end
      S_SEND: begin
        if (bit_end) begin
          cyc_d = '0;
          if (pixel_end) begin
            idx_d = '0;
            if (pixelValid) shift_d = pixelData;
            else            state_d = S_IDLE;
          end else begin
            shift_d = shift_q << 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (latch_end) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Bench for ws2812_pixel_serializer: default 24-bit instance and a 32-bit
// RGBW instance, cycle-exact waveform model plus a pulse-decoding scoreboard.
module tb_ws2812_pixel_serializer;

  localparam int RC = 6000;
  int pb[2] = '{24, 32};
  int bc[2] = '{120, 125};
  int t0[2] = '{35, 40};
  int t1[2] = '{70, 80};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_valid, a_latch, a_ready, a_dout, a_busy, a_pdone, a_ldone;
  logic [23:0] a_data;
  logic [1:0]  a_dbg;
  logic        b_reset, b_valid, b_latch, b_ready, b_dout, b_busy, b_pdone, b_ldone;
  logic [31:0] b_data;
  logic [1:0]  b_dbg;

  ws2812_pixel_serializer dut_a (
    .clk(clk), .reset(a_reset), .pixelData(a_data), .pixelValid(a_valid),
    .pixelReady(a_ready), .latchReq(a_latch), .dataOut(a_dout), .busy(a_busy),
    .pixelDone(a_pdone), .latchDone(a_ldone), .dbg_state_o(a_dbg)
  );

  ws2812_pixel_serializer #(
    .PIXEL_BITS(32), .BIT_CYC(125), .T0H_CYC(40), .T1H_CYC(80)
  ) dut_b (
    .clk(clk), .reset(b_reset), .pixelData(b_data), .pixelValid(b_valid),
    .pixelReady(b_ready), .latchReq(b_latch), .dataOut(b_dout), .busy(b_busy),
    .pixelDone(b_pdone), .latchDone(b_ldone), .dbg_state_o(b_dbg)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drv_px(input int s, input logic v, input logic [31:0] px);
    if (s == 0) begin a_valid = v; a_data = px[23:0]; end
    else        begin b_valid = v; b_data = px;       end
  endtask

  task automatic drv_latch(input int s, input logic v);
    if (s == 0) a_latch = v; else b_latch = v;
  endtask

  task automatic drv_reset(input int s, input logic v);
    if (s == 0) a_reset = v; else b_reset = v;
  endtask

  task automatic smp(input int s, output logic d, output logic r, output logic b,
                     output logic pd, output logic ld);
    if (s == 0) begin d = a_dout; r = a_ready; b = a_busy; pd = a_pdone; ld = a_ldone; end
    else        begin d = b_dout; r = b_ready; b = b_busy; pd = b_pdone; ld = b_ldone; end
  endtask

  // Expected line level at cycle i (0-based) inside a pixel.
  function automatic logic exp_line(input int s, input int i, input logic [31:0] px);
    int bitn, c;
    logic d;
    bitn = i / bc[s];
    c    = i % bc[s];
    d    = px[pb[s]-1-bitn];
    return (c < (d ? t1[s] : t0[s]));
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  task automatic push_exp(input int s, input logic [31:0] px);
    if (s == 0) exp_q_a.push_back(px); else exp_q_b.push_back(px);
  endtask

  int          hi[2];
  int          nb[2];
  logic [31:0] acc[2];
  logic        prev[2];

  // Decodes bits from high-pulse widths and compares each finished pixel.
  task automatic mon(input int s, input logic d, input logic rst);
    logic [31:0] e;
    if (rst) begin
      hi[s] = 0; nb[s] = 0; acc[s] = '0; prev[s] = 1'b0;
      return;
    end
    if (d) hi[s]++;
    else if (prev[s]) begin
      if (hi[s] == t1[s])      acc[s] = {acc[s][30:0], 1'b1};
      else if (hi[s] == t0[s]) acc[s] = {acc[s][30:0], 1'b0};
      else begin
        check(s == 0 ? "a_hi_width" : "b_hi_width", hi[s], t0[s]);
        acc[s] = {acc[s][30:0], 1'b0};
      end
      hi[s] = 0;
      nb[s]++;
      if (nb[s] == pb[s]) begin
        if (s == 0 && exp_q_a.size() > 0)      begin e = exp_q_a.pop_front(); check("a_sb_pix", acc[s], e); end
        else if (s == 1 && exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); check("b_sb_pix", acc[s], e); end
        else check(s == 0 ? "a_sb_unexp" : "b_sb_unexp", acc[s], 32'hFFFF_FFFF);
        nb[s] = 0; acc[s] = '0;
      end
    end
    prev[s] = d;
  endtask

  always @(negedge clk) begin
    mon(0, a_dout, a_reset);
    mon(1, b_dout, b_reset);
  end

  // ---------------- test tasks ----------------
  // Sends npix pixels (valid held between them) and checks every cycle.
  task automatic run_px(input int s, input int npix, input logic [31:0] px0,
                        input logic [31:0] px1, input string tag);
    int pc, ncyc, wm, rm, dm, bm, lm, first_done, idx, p;
    logic d, r, b, pd, ld, ed, er, epd;
    pc = pb[s] * bc[s];
    ncyc = npix * pc + 1;
    wm = 0; rm = 0; dm = 0; bm = 0; lm = 0; first_done = -1;
    @(negedge clk);
    smp(s, d, r, b, pd, ld);
    check({tag, "_rdy0"}, r, 1);
    drv_px(s, 1'b1, px0);
    push_exp(s, px0);
    if (npix > 1) push_exp(s, px1);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      if (k == 1 && npix > 1) drv_px(s, 1'b1, px1);
      if (k == (npix - 1) * pc + 1) drv_px(s, 1'b0, px1);
      @(negedge clk);
      smp(s, d, r, b, pd, ld);
      idx = k - 1;
      p   = idx / pc;
      ed  = (p < npix) ? exp_line(s, idx % pc, (p == 0) ? px0 : px1) : 1'b0;
      epd = (k <= npix * pc) && (k % pc == 0);
      er  = (k <= npix * pc) ? epd : 1'b1;
      if (d !== ed) wm++;
      if (r !== er) rm++;
      if (pd !== epd) dm++;
      if (b !== (k <= npix * pc)) bm++;
      if (ld !== 1'b0) lm++;
      if (pd === 1'b1 && first_done < 0) first_done = k;
    end
    check({tag, "_wave_err"}, wm, 0);
    check({tag, "_ready_err"}, rm, 0);
    check({tag, "_done_err"}, dm, 0);
    check({tag, "_busy_err"}, bm, 0);
    check({tag, "_ldone_err"}, lm, 0);
    check({tag, "_done_at"}, first_done, pc);
  endtask

  // Latch period, optionally requested together with a pixel in the same cycle.
  task automatic run_latch(input int s, input bit with_px, input logic [31:0] px,
                           input string tag);
    int pc, idle_k, ls, tot, wm, rm, bm, lm, first_ld;
    logic d, r, b, pd, ld, ed, er, eb;
    pc     = with_px ? pb[s] * bc[s] : 0;
    idle_k = with_px ? pc + 1 : -1;
    ls     = with_px ? pc + 1 : 0;
    tot    = ls + RC + 1;
    wm = 0; rm = 0; bm = 0; lm = 0; first_ld = -1;
    @(negedge clk);
    drv_latch(s, 1'b1);
    if (with_px) begin
      drv_px(s, 1'b1, px);
      push_exp(s, px);
    end
    for (int k = 1; k <= tot; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        drv_px(s, 1'b0, px);
        if (!with_px) drv_latch(s, 1'b0);
      end
      @(negedge clk);
      smp(s, d, r, b, pd, ld);
      ed = (k <= pc) ? exp_line(s, k - 1, px) : 1'b0;
      er = (with_px && k == pc) || (k == idle_k) || (k == tot);
      eb = !((k == idle_k) || (k == tot));
      if (d !== ed) wm++;
      if (r !== er) rm++;
      if (b !== eb) bm++;
      if (ld !== (k == ls + RC)) lm++;
      if (ld === 1'b1) begin
        if (first_ld < 0) first_ld = k;
        drv_latch(s, 1'b0);
      end
    end
    check({tag, "_wave_err"}, wm, 0);
    check({tag, "_ready_err"}, rm, 0);
    check({tag, "_busy_err"}, bm, 0);
    check({tag, "_ldone_err"}, lm, 0);
    check({tag, "_ldone_at"}, first_ld, ls + RC);
  endtask

  // Reset asserted during cycle 'at' of a pixel; the pixel is abandoned.
  task automatic run_abort(input int s, input logic [31:0] px, input int at, input string tag);
    logic d, r, b, pd, ld;
    @(negedge clk);
    drv_px(s, 1'b1, px);
    push_exp(s, px);
    for (int k = 1; k <= at; k++) begin
      @(posedge clk); #1;
      if (k == 1) drv_px(s, 1'b0, px);
    end
    drv_reset(s, 1'b1);
    @(posedge clk);
    @(negedge clk);
    smp(s, d, r, b, pd, ld);
    check({tag, "_dout"}, d, 0);
    check({tag, "_busy"}, b, 0);
    check({tag, "_ready_in_rst"}, r, 0);
    check({tag, "_state"}, (s == 0) ? a_dbg : b_dbg, 0);
    if (s == 0) void'(exp_q_a.pop_back()); else void'(exp_q_b.pop_back());
    @(posedge clk); #1;
    drv_reset(s, 1'b0);
    @(negedge clk);
    smp(s, d, r, b, pd, ld);
    check({tag, "_ready_after"}, r, 1);
    check({tag, "_busy_after"}, b, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r0, r1;
    a_reset = 1'b1; a_valid = 1'b0; a_latch = 1'b0; a_data = '0;
    b_reset = 1'b1; b_valid = 1'b0; b_latch = 1'b0; b_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", a_ready, 0);
    check("rst_a_dout", a_dout, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_pulses", {a_pdone, a_ldone}, 0);
    check("rst_a_state", a_dbg, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_b_dout", b_dout, 0);
    @(posedge clk); #1;
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
    check("rel_a_ready", a_ready, 1);
    check("rel_a_busy", a_busy, 0);
    check("rel_b_ready", b_ready, 1);

    run_px(0, 1, 32'h0080_0000, 32'h0, "a_single");
    run_px(0, 2, 32'h00FF_FFFF, 32'h0000_0000, "a_b2b");
    run_latch(0, 1'b0, 32'h0, "a_latch");
    run_latch(0, 1'b1, 32'h003C_5A96, "a_prio");
    run_abort(0, 32'h00C3_A5F0, 500, "a_abort");
    run_px(0, 1, 32'h005A_0F33, 32'h0, "a_post_rst");
    r0 = $urandom_range(32'h00FF_FFFF, 0);
    r1 = $urandom_range(32'h00FF_FFFF, 0);
    run_px(0, 2, r0, r1, "a_rand");

    run_px(1, 1, 32'hA5A5_A5A5, 32'h0, "b_single");
    r0 = $urandom;
    r1 = $urandom;
    run_px(1, 2, r0, r1, "b_rand");

    repeat (2) @(negedge clk);
    check("a_sb_left", exp_q_a.size(), 0);
    check("b_sb_left", exp_q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_pixel_serializer.md
Name: ws2812_pixel_serializer

Overview:
- Parametrised successor to the single-bit WS2812B generator.
- Accepts whole pixels (default 24-bit GRB) over a valid/ready handshake and shifts them out MSB-first as WS2812B-timed pulses, back-to-back with no inter-pixel gap.
- Generates the end-of-frame latch (reset-low) period itself, so the strip controller only supplies pixel words and a latch request.
- Sits between the frame/pixel controller and the strip data pin.

Parameters:
- PIXEL_BITS, 24: bits per pixel (24 = GRB, 32 = RGBW).
- BIT_CYC, 120: clk cycles per bit period (1200 ns at 100 MHz).
- T0H_CYC, 35: high cycles for a '0' bit.
- T1H_CYC, 70: high cycles for a '1' bit.
- RESET_CYC, 6000: low cycles for the latch period (60 us).
- CNT_W, 13: cycle counter width. Must hold max(BIT_CYC, RESET_CYC)-1.
- Legal set: 0 < T0H_CYC < T1H_CYC < BIT_CYC; RESET_CYC >= 1; PIXEL_BITS >= 1.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- pixelData  in  PIXEL_BITS  pixel word; MSB is transmitted first.
- pixelValid  in  1  pixelData is valid.
- pixelReady  out  1  block accepts pixelData this cycle.
- latchReq  in  1  level request to emit the latch period.
- dataOut  out  1  serial line to the LED strip.
- busy  out  1  high in SEND or LATCH.
- pixelDone  out  1  one-cycle pulse on the last cycle of each pixel.
- latchDone  out  1  one-cycle pulse on the last cycle of the latch period.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- While reset is high: state = IDLE, counters = 0, shift register = 0, dataOut = 0, busy = 0, pixelDone = 0, latchDone = 0, pixelReady = 0.
- Reset mid-pixel or mid-latch aborts immediately; nothing is resumed.
- Registers:
  - state: IDLE / SEND / LATCH.
  - shiftReg[PIXEL_BITS-1:0].
  - bitIdx, width clog2(PIXEL_BITS).
  - cyc[CNT_W-1:0].
- Handshake: a transfer occurs on a clk edge where pixelValid && pixelReady.
- pixelReady decode (excluding reset): (state==IDLE) || (state==SEND && bitIdx==PIXEL_BITS-1 && cyc==BIT_CYC-1).
- IDLE:
  - dataOut = 0.
  - If pixelValid: load shiftReg, bitIdx = 0, cyc = 0, go to SEND.
  - Else if latchReq: cyc = 0, go to LATCH.
  - pixelValid has priority over latchReq.
- SEND:
  - dataOut = (cyc < (shiftReg[PIXEL_BITS-1] ? T1H_CYC : T0H_CYC)).
  - dataOut is decoded from registers only; there is no combinational path from any input.
  - cyc increments each cycle.
  - At cyc == BIT_CYC-1: cyc = 0, shiftReg <<= 1, bitIdx += 1.
  - At the last cycle of the last bit: pixelDone = 1.
    - If pixelValid: reload shiftReg, bitIdx = 0, stay in SEND (gapless).
    - Else: go to IDLE.
  - latchReq is ignored in SEND.
- Latency: the first high cycle of a pixel is the cycle after the accepting edge. One pixel occupies exactly PIXEL_BITS*BIT_CYC cycles.
- LATCH:
  - dataOut = 0; pixelReady = 0.
  - cyc increments each cycle.
  - At cyc == RESET_CYC-1: latchDone = 1, go to IDLE.
  - If latchReq is still high on return to IDLE, another latch period starts. The controller must drop latchReq on latchDone.
- busy = (state != IDLE).
- Underrun: if no pixel is available at a pixel boundary, the line idles low. Gaps of 5 us or more may latch the strip; the controller is responsible for keeping the FIFO fed.
- Arithmetic: all compares are unsigned. cyc never exceeds max(BIT_CYC, RESET_CYC)-1. bitIdx never exceeds PIXEL_BITS-1.

Test Plan:
- Single pixel 24'h800000 with default parameters:
  - Bit 23: dataOut high for cycles 1-70, low for 71-120.
  - Bits 22..0: high 35 cycles, low 85 cycles each.
  - pixelDone at cycle 2880; IDLE with pixelReady = 1 at cycle 2881.
- Back-to-back 24'hFFFFFF then 24'h000000 with pixelValid held high:
  - pixelReady pulses exactly at cycle 2880.
  - The second pixel's first high cycle is 2881 (no gap).
  - The second pixel shows 24 bits of 35 high / 85 low.
- latchReq pulsed in IDLE:
  - dataOut low and busy high for 6000 cycles.
  - latchDone at cycle 6000; pixelReady = 0 throughout.
- pixelValid and latchReq asserted in the same IDLE cycle:
  - The pixel is sent first.
  - LATCH starts after pixelDone only if latchReq is still high and no new pixel is valid.
- Reset asserted at cycle 500 of a pixel:
  - dataOut = 0 and busy = 0 on the next cycle.
  - After release, pixelReady = 1 and a new pixel is sent from its MSB.
- Overrides PIXEL_BITS=32, BIT_CYC=125, T0H_CYC=40, T1H_CYC=80 with 32'hA5A5A5A5:
  - Pulse widths alternate 80/40 high per the data pattern.
  - pixelDone at cycle 4000.
